tdc_hostif: RTL and testbench
=============================

Name: tdc_hostif

Overview:
- CSR-bus slave that buffers TDC timestamp events for the LM32 to read.
- Captures one event per cycle from the TDC core event stream into a 16-entry FIFO and exposes status, data, pop and control registers.
- Raises a level interrupt while events are pending.
- Ships as the next CSR peripheral after uart (0x0) and sysctl (0x1). Its csr_do is ORed into the csrbrg read-data mux, and its irq takes cpu_interrupt bit 5.

Parameters:
- csr_addr, 4'h2, CSR page; block is selected when csr_a[13:10] == csr_addr.
- depth_log2, 4, FIFO depth is 2**depth_log2 = 16 entries.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  synchronous reset, active-low.
- csr_a  in  14  CSR address; [2:0] selects the register.
- csr_we  in  1  CSR write strobe.
- csr_di  in  32  CSR write data.
- csr_do  out  32  CSR read data, registered; 0 when not selected.
- ev_stb  in  1  event valid, single-cycle, cannot be stalled.
- ev_chan  in  3  channel index.
- ev_pol  in  1  edge polarity (1 = rising).
- ev_ts  in  28  timestamp.
- irq  out  1  level interrupt.

Behaviour:
- Reset (sys_rst_n low at a sys_clk edge): FIFO empty, overflow=0, drops=0, enable=0, irq_en=0, csr_do=0, irq=0. Reset asserted mid-operation discards all entries in the same edge.
- Entry format: {ev_pol[31], ev_chan[30:28], ev_ts[27:0]}.
- Register map (index = csr_a[2:0]):
  - 0 STATUS (RO): [0] nonempty, [1] overflow (sticky), [8:4] level 0..16.
  - 1 DATA (RO): head entry with no side effect; reads 0 when empty.
  - 2 POP (WO): any write pops one entry.
  - 3 CTRL (RW): [0] enable, [1] irq_en. A write with [2]=1 flushes the FIFO and clears overflow; [2] always reads 0.
  - 4 DROPS (RO): 16-bit saturating count of dropped events. Any write to index 4 clears it.
  - Indices 5..7: read 0, writes ignored.
- CSR read latency: csr_do is valid one cycle after csr_a is presented. When the page does not match, csr_do is 0 on the next cycle.
- Writes take effect at the edge where csr_we=1 and the page matches.
- Push rule: ev_stb & enable & not full pushes.
  - ev_stb & enable & full: event dropped, overflow set, drops incremented (saturates at 16'hFFFF).
  - ev_stb & !enable: ignored and not counted.
- Pop on empty: ignored, with no underflow flag.
- Simultaneous push and pop:
  - Nonempty and not full: both occur and level is unchanged.
  - Full: pop frees a slot, the push is accepted, level stays 16, no drop.
  - Empty: the push is accepted and the pop is ignored; level becomes 1.
- Flush in the same cycle as ev_stb: flush wins and the event is discarded without being counted.
- Pointers are depth_log2 bits and wrap modulo 16. Level is a depth_log2+1 bit counter.
- irq = irq_en & nonempty, registered, so it rises one cycle after the push edge.
- FIFO storage is inferred distributed RAM with an asynchronous head read into the csr_do register.

Optional Feature:
- Macro: TDC_HOSTIF_WATERMARK_EN.
- Defined:
  - CTRL[8:4] holds a watermark W (RW, reset 1).
  - irq = irq_en & (level >= W). W=0 behaves as W=1.
- Undefined: CTRL[8:4] reads 0 and writes are ignored; irq = irq_en & nonempty.

Decomposition:
- Package tdc_hostif_pkg:
  - register index constants (STATUS=0, DATA=1, POP=2, CTRL=3, DROPS=4);
  - CTRL bit positions;
  - entry field offsets;
  - DROPS saturation value.
- Sub-module tdc_hostif_fifo:
  - synchronous FIFO with push, pop, flush, head, level, full and empty;
  - parameterised by width and depth_log2.
- The top level holds CSR decode, control regs, drop counter and irq.

Test Plan:
- Reset, then read STATUS and DROPS -> both 0; irq=0.
- CTRL=3; one event with chan=5, pol=1, ts=28'h0ABCDEF -> DATA=32'hD0ABCDEF, STATUS=32'h11, irq=1 one cycle later. Write POP -> STATUS=0, irq=0.
- Enable; push 18 events -> level=16, overflow=1, DROPS=2. DATA shows the 1st event; the 16th pop returns the 16th event.
- Full FIFO, then ev_stb and POP in the same cycle -> level stays 16 and DROPS is unchanged.
- CTRL write 32'h5 with ev_stb in the same cycle -> STATUS=0 and DROPS unchanged. Wrap test: 40 push/pop pairs -> data order preserved.
- With TDC_HOSTIF_WATERMARK_EN and CTRL={W=4, irq_en, enable}: irq=0 at level 3, irq=1 at level 4. Reset asserted with level 4 -> level 0 and irq=0 next cycle.

Source files
------------

// File: rtl/tdc_hostif_pkg.sv
// tdc_hostif shared constants: register map, CTRL/STATUS bits, entry layout.
// Watermark constants exist only when TDC_HOSTIF_WATERMARK_EN is defined.
package tdc_hostif_pkg;

  localparam logic [2:0] REG_STATUS = 3'd0;
  localparam logic [2:0] REG_DATA   = 3'd1;
  localparam logic [2:0] REG_POP    = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;
  localparam logic [2:0] REG_DROPS  = 3'd4;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_FLUSH  = 2;
`ifdef TDC_HOSTIF_WATERMARK_EN
  localparam int CTRL_WM_LO  = 4;
  localparam int CTRL_WM_W   = 5;
`endif

  localparam int ST_NONEMPTY = 0;
  localparam int ST_OVF      = 1;
  localparam int ST_LEVEL_LO = 4;

  localparam int ENT_POL     = 31;
  localparam int ENT_CHAN_LO = 28;
  localparam int ENT_TS_W    = 28;

  localparam logic [15:0] DROPS_MAX = 16'hFFFF;

  function automatic logic [31:0] pack_entry(
    input logic                pol,
    input logic [2:0]          chan,
    input logic [ENT_TS_W-1:0] ts
  );
    logic [31:0] e;
    e = '0;
    e[ENT_POL] = pol;
    e[ENT_CHAN_LO +: 3] = chan;
    e[ENT_TS_W-1:0] = ts;
    return e;
  endfunction

endpackage

// File: rtl/tdc_hostif_fifo.sv
// Synchronous FIFO with flush; distributed RAM, asynchronous head read.
// Pop on empty is ignored; a push on full is accepted only alongside a pop.
module tdc_hostif_fifo #(
  parameter int width      = 32,
  parameter int depth_log2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [width-1:0]      din,
  output logic [width-1:0]      head,
  output logic [depth_log2:0]   level,
  output logic                  full,
  output logic                  empty
);

  logic [width-1:0]      mem [2**depth_log2];
  logic [depth_log2-1:0] wr_ptr;
  logic [depth_log2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (level == '0);
  assign full    = level[depth_log2];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      level <= level
             + {{depth_log2{1'b0}}, do_push}
             - {{depth_log2{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush)
      mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/tdc_hostif.sv
// CSR slave buffering TDC events for the CPU; level irq while pending.
// Optional TDC_HOSTIF_WATERMARK_EN adds an irq level watermark in CTRL[8:4].
import tdc_hostif_pkg::*;

module tdc_hostif #(
  parameter logic [3:0] csr_addr   = 4'h2,
  parameter int         depth_log2 = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  input  logic        ev_stb,
  input  logic [2:0]  ev_chan,
  input  logic        ev_pol,
  input  logic [27:0] ev_ts,
  output logic        irq
);

  logic        sel;
  logic        wr;
  logic [2:0]  idx;
  logic        pop_wr;
  logic        ctrl_wr;
  logic        flush;
  logic        drops_clr;
  logic        push;
  logic        drop;
  logic        ctrl_en;
  logic        ctrl_irq_en;
  logic        ovf;
  logic [15:0] drops;
  logic [31:0] head;
  logic [31:0] rd_data;
  logic [31:0] lvl32;
  logic        irq_d;
  logic [depth_log2:0] level;
  logic        full;
  logic        empty;
  logic        unused_bits;

  assign sel       = (csr_a[13:10] == csr_addr);
  assign idx       = csr_a[2:0];
  assign wr        = csr_we & sel;
  assign pop_wr    = wr & (idx == REG_POP);
  assign ctrl_wr   = wr & (idx == REG_CTRL);
  assign flush     = ctrl_wr & csr_di[CTRL_FLUSH];
  assign drops_clr = wr & (idx == REG_DROPS);
  assign unused_bits = ^{csr_a[9:3], csr_di[31:3]};

  // Flush wins over a coincident event: it is neither stored nor counted.
  assign push = ev_stb & ctrl_en & ~flush;
  assign drop = push & full & ~pop_wr;

  tdc_hostif_fifo #(
    .width      (32),
    .depth_log2 (depth_log2)
  ) u_fifo (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .push  (push),
    .pop   (pop_wr),
    .flush (flush),
    .din   (pack_entry(ev_pol, ev_chan, ev_ts)),
    .head  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      ovf         <= 1'b0;
      drops       <= '0;
    end else begin
      if (ctrl_wr) begin
        ctrl_en     <= csr_di[CTRL_EN];
        ctrl_irq_en <= csr_di[CTRL_IRQ_EN];
      end
      if (flush)
        ovf <= 1'b0;
      else if (drop)
        ovf <= 1'b1;
      if (drops_clr)
        drops <= '0;
      else if (drop && drops != DROPS_MAX)
        drops <= drops + 16'd1;
    end
  end

  assign lvl32 = 32'(level);

`ifdef TDC_HOSTIF_WATERMARK_EN
  logic [CTRL_WM_W-1:0] wm;
  logic [31:0]          wm_eff;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n)
      wm <= CTRL_WM_W'(1);
    else if (ctrl_wr)
      wm <= csr_di[CTRL_WM_LO +: CTRL_WM_W];
  end

  assign wm_eff = (wm == '0) ? 32'd1 : 32'(wm);
  assign irq_d  = ctrl_irq_en & (lvl32 >= wm_eff);
`else
  assign irq_d  = ctrl_irq_en & ~empty;
`endif

  always_comb begin
    rd_data = '0;
    unique case (idx)
      REG_STATUS: begin
        rd_data[ST_NONEMPTY] = ~empty;
        rd_data[ST_OVF]      = ovf;
        rd_data[ST_LEVEL_LO +: depth_log2+1] = level;
      end
      REG_DATA:   rd_data = empty ? '0 : head;
      REG_CTRL: begin
        rd_data[CTRL_EN]     = ctrl_en;
        rd_data[CTRL_IRQ_EN] = ctrl_irq_en;
`ifdef TDC_HOSTIF_WATERMARK_EN
        rd_data[CTRL_WM_LO +: CTRL_WM_W] = wm;
`endif
      end
      REG_DROPS:  rd_data[15:0] = drops;
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      csr_do <= '0;
      irq    <= 1'b0;
    end else begin
      csr_do <= sel ? rd_data : '0;
      irq    <= irq_d;
    end
  end

endmodule

// File: tb/tb_tdc_hostif.sv
// Directed self-checking bench for tdc_hostif.
// Also runs with TDC_HOSTIF_WATERMARK_EN defined.
module tb_tdc_hostif;

  logic        sys_clk;
  logic        sys_rst_n;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;
  logic        ev_stb;
  logic [2:0]  ev_chan;
  logic        ev_pol;
  logic [27:0] ev_ts;
  logic        irq;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] rd;

  tdc_hostif dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .csr_a     (csr_a),
    .csr_we    (csr_we),
    .csr_di    (csr_di),
    .csr_do    (csr_do),
    .ev_stb    (ev_stb),
    .ev_chan   (ev_chan),
    .ev_pol    (ev_pol),
    .ev_ts     (ev_ts),
    .irq       (irq)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ent(input int i);
    logic [31:0] v;
    v = i;
    return {v[0], v[2:0], v[27:0]};
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_ev(input int i);
    logic [31:0] e;
    e = ent(i);
    ev_stb  = 1'b1;
    ev_pol  = e[31];
    ev_chan = e[30:28];
    ev_ts   = e[27:0];
  endtask

  task automatic set_wr(input logic [2:0] idx, input logic [31:0] d);
    csr_a  = {4'h2, 7'd0, idx};
    csr_we = 1'b1;
    csr_di = d;
  endtask

  task automatic idle();
    ev_stb = 1'b0;
    csr_we = 1'b0;
  endtask

  task automatic ev(input int i);
    set_ev(i);
    tick();
    idle();
  endtask

  task automatic csr_wr(input logic [2:0] idx, input logic [31:0] d);
    set_wr(idx, d);
    tick();
    idle();
  endtask

  task automatic csr_rd(input logic [2:0] idx, output logic [31:0] d);
    csr_a  = {4'h2, 7'd0, idx};
    csr_we = 1'b0;
    tick();
    d = csr_do;
  endtask

  initial begin
    sys_rst_n = 1'b0;
    csr_a = '0; csr_we = 1'b0; csr_di = '0;
    ev_stb = 1'b0; ev_chan = '0; ev_pol = 1'b0; ev_ts = '0;
    repeat (3) tick();
    check("rst_csr_do", csr_do, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    sys_rst_n = 1'b1;
    csr_rd(3'd0, rd); check("rst_status", rd, 32'h0);
    csr_rd(3'd4, rd); check("rst_drops", rd, 32'h0);

    // single event
    csr_wr(3'd3, 32'h3);
    ev_stb = 1'b1; ev_chan = 3'd5; ev_pol = 1'b1; ev_ts = 28'h0ABCDEF;
    tick(); idle();
    check("irq_lag", {31'b0, irq}, 32'h0);
    csr_rd(3'd1, rd); check("data_one", rd, 32'hD0ABCDEF);
    check("irq_one", {31'b0, irq}, 32'h1);
    csr_rd(3'd0, rd); check("status_one", rd, 32'h11);
    csr_wr(3'd2, 32'h0);
    csr_rd(3'd0, rd); check("status_pop", rd, 32'h0);
    check("irq_pop", {31'b0, irq}, 32'h0);

    // overflow
    for (int i = 0; i < 18; i++) ev(i);
    csr_rd(3'd0, rd); check("status_full", rd, 32'h103);
    csr_rd(3'd4, rd); check("drops_2", rd, 32'h2);
    csr_rd(3'd1, rd); check("data_first", rd, ent(0));

    // push and pop together while full
    set_ev(100); set_wr(3'd2, 32'h0); tick(); idle();
    csr_rd(3'd0, rd); check("status_full_pp", rd, 32'h103);
    csr_rd(3'd4, rd); check("drops_full_pp", rd, 32'h2);
    for (int i = 0; i < 14; i++) csr_wr(3'd2, 32'h0);
    csr_rd(3'd1, rd); check("data_16th", rd, ent(15));
    csr_wr(3'd2, 32'h0);
    csr_rd(3'd1, rd); check("data_pp", rd, ent(100));
    csr_wr(3'd2, 32'h0);
    csr_rd(3'd0, rd); check("status_drained", rd, 32'h2);
    csr_rd(3'd1, rd); check("data_empty", rd, 32'h0);
    csr_wr(3'd2, 32'h0);
    csr_rd(3'd0, rd); check("pop_empty", rd, 32'h2);

    // flush beats a coincident event
    set_ev(7); set_wr(3'd3, 32'h5); tick(); idle();
    csr_rd(3'd0, rd); check("status_flush", rd, 32'h0);
    csr_rd(3'd4, rd); check("drops_flush", rd, 32'h2);
    csr_rd(3'd3, rd); check("ctrl_rb", rd, 32'h1);
    csr_wr(3'd4, 32'h0);
    csr_rd(3'd4, rd); check("drops_clr", rd, 32'h0);
    csr_rd(3'd5, rd); check("reg5", rd, 32'h0);
    csr_a = {4'h3, 7'd0, 3'd0};
    tick();
    check("page_miss", csr_do, 32'h0);

    // push and pop together while empty
    set_ev(9); set_wr(3'd2, 32'h0); tick(); idle();
    csr_rd(3'd0, rd); check("status_empty_pp", rd, 32'h11);
    csr_rd(3'd1, rd); check("data_empty_pp", rd, ent(9));
    csr_wr(3'd2, 32'h0);

    // pointer wrap
    for (int i = 0; i < 40; i++) begin
      ev(200 + i);
      csr_rd(3'd1, rd); check($sformatf("wrap%0d", i), rd, ent(200 + i));
      csr_wr(3'd2, 32'h0);
    end
    csr_rd(3'd0, rd); check("status_wrap", rd, 32'h0);

    // irq threshold and mid-run reset
`ifdef TDC_HOSTIF_WATERMARK_EN
    csr_wr(3'd3, 32'h43);
    csr_rd(3'd3, rd); check("ctrl_wm", rd, 32'h43);
`else
    csr_wr(3'd3, 32'h3);
`endif
    for (int i = 0; i < 3; i++) ev(300 + i);
    tick();
`ifdef TDC_HOSTIF_WATERMARK_EN
    check("irq_lvl3", {31'b0, irq}, 32'h0);
`else
    check("irq_lvl3", {31'b0, irq}, 32'h1);
`endif
    ev(303);
    tick();
    check("irq_lvl4", {31'b0, irq}, 32'h1);
    sys_rst_n = 1'b0;
    tick();
    check("rst_mid_irq", {31'b0, irq}, 32'h0);
    check("rst_mid_do", csr_do, 32'h0);
    sys_rst_n = 1'b1;
    csr_rd(3'd0, rd); check("rst_mid_status", rd, 32'h0);
    csr_rd(3'd3, rd);
`ifdef TDC_HOSTIF_WATERMARK_EN
    check("rst_mid_ctrl", rd, 32'h10);
`else
    check("rst_mid_ctrl", rd, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
